// File: rtl/core_pkg.sv
// Shared core definitions: data width, default reset PC and the fetch-control state type.
// Latency: n/a (package only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN = 32;

    // First fetch address after reset unless the instantiation overrides it.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } pc_state_t;

    // Instructions are 32-bit, so a legal target has its two low bits clear.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/branch_stats.sv
// Saturating event counters for accepted and misaligned redirects.
// Latency: a count reflects an event one clock after the event's inc strobe.
// Backpressure: none; counters stick at all-ones instead of wrapping.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset (clears both counts)
//   inc_redirect     one accepted redirect this cycle
//   inc_misalign     one misaligned redirect this cycle
//   redirect_count   accepted redirects since reset
//   misalign_count   misaligned redirects since reset
module branch_stats
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_redirect,
    input  logic            inc_misalign,
    output logic [XLEN-1:0] redirect_count,
    output logic [XLEN-1:0] misalign_count
);

    localparam logic [XLEN-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_count <= '0;
            misalign_count <= '0;
        end else begin
            if (inc_redirect && (redirect_count != CNT_MAX)) begin
                redirect_count <= redirect_count + 32'd1;
            end
            if (inc_misalign && (misalign_count != CNT_MAX)) begin
                misalign_count <= misalign_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: boots at RESET_PC, steps by 4, and takes EX-stage redirects with a one-cycle fetch bubble.
// Latency: a redirect updates pc_out on the next edge; flushes are combinational in the redirect cycle.
// Backpressure: PC holds while stall is high or imem_ready is low; an accepted redirect overrides both.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   stall             load-use hold from the hazard unit
//   redirect_valid    EX-stage taken branch/jump
//   redirect_target   EX-stage target address
//   imem_ready        instruction memory accepts the current fetch
//   pc_out            current fetch address
//   fetch_valid       pc_out is a live fetch request (high only in RUN)
//   flush_ifid/idex   squash IF/ID and ID/EX this cycle
//   misaligned_err    one-cycle pulse after a redirect to a non-word-aligned target
// Optional (macro BRANCH_STATS_EN): redirect_count, misalign_count saturating statistics.
module pc_redirect_ctrl
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_valid,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misaligned_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [XLEN-1:0] redirect_count,
    output logic [XLEN-1:0] misalign_count
`endif
);

    pc_state_t state;

    logic target_aligned;
    logic redirect_accept;
    logic redirect_misalign;

    assign target_aligned = is_word_aligned(redirect_target);

    // Redirects are ignored in BOOT, and a reset in the same cycle wins over
    // everything, so neither event is reported while rst is high.
    assign redirect_accept   = redirect_valid &&  target_aligned && (state != BOOT) && !rst;
    assign redirect_misalign = redirect_valid && !target_aligned && (state != BOOT) && !rst;

    assign flush_ifid  = redirect_accept;
    assign flush_idex  = redirect_accept;
    assign fetch_valid = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= BOOT;
            pc_out         <= RESET_PC;
            misaligned_err <= 1'b0;
        end else begin
            misaligned_err <= redirect_misalign;
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, BUBBLE: begin
                    if (redirect_accept) begin
                        // A redirect seen in BUBBLE restarts the bubble.
                        pc_out <= redirect_target;
                        state  <= BUBBLE;
                    end else begin
                        state <= RUN;
                        // Only a live fetch that memory accepted moves the PC;
                        // in BUBBLE the target is held so it gets fetched next.
                        if ((state == RUN) && imem_ready && !stall) begin
                            pc_out <= pc_out + 32'd4;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    branch_stats u_branch_stats (
        .clk            (clk),
        .rst            (rst),
        .inc_redirect   (redirect_accept),
        .inc_misalign   (redirect_misalign),
        .redirect_count (redirect_count),
        .misalign_count (misalign_count)
    );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed, table-driven bench for pc_redirect_ctrl with RESET_PC = 0x100.
// Each row gives the inputs for one cycle and the outputs expected in that same cycle.
// Hand sequences cover reset during a bubble, redirect chains in BUBBLE and the optional counters.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misaligned_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] misalign_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .pc_out          (pc_out),
        .fetch_valid     (fetch_valid),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .misaligned_err  (misaligned_err)
`ifdef BRANCH_STATS_EN
        ,
        .redirect_count  (redirect_count),
        .misalign_count  (misalign_count)
`endif
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] exp_pc;
        logic        exp_fv;
        logic        exp_fl;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] tgt,
                                input logic rdy, input logic [31:0] pc,
                                input logic fv, input logic fl, input logic err);
        vec_t v;
        v.stall = s;  v.rv = rv;  v.tgt = tgt;  v.rdy = rdy;
        v.exp_pc = pc;  v.exp_fv = fv;  v.exp_fl = fl;  v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge; outputs are sampled 1 time unit later,
    // well clear of the next rising edge.
    task automatic drive(input logic r, input logic s, input logic rv,
                         input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        rst = r;  stall = s;  redirect_valid = rv;  redirect_target = tgt;  imem_ready = rdy;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] pc, input logic fv,
                            input logic fl, input logic err);
        chk({tag, " pc_out"},         pc_out,               pc);
        chk({tag, " fetch_valid"},    {31'd0, fetch_valid}, {31'd0, fv});
        chk({tag, " flush_ifid"},     {31'd0, flush_ifid},  {31'd0, fl});
        chk({tag, " flush_idex"},     {31'd0, flush_idex},  {31'd0, fl});
        chk({tag, " misaligned_err"}, {31'd0, misaligned_err}, {31'd0, err});
    endtask

    initial begin
        rst = 1'b1;  stall = 1'b0;  redirect_valid = 1'b0;
        redirect_target = 32'd0;  imem_ready = 1'b0;

        //             stall rv  target        rdy  exp_pc        fv  fl  err
        tbl[0]  = mk(0, 1, 32'h0000_0300, 1, 32'h0000_0100, 0, 0, 0); // BOOT: redirect ignored
        tbl[1]  = mk(0, 0, 32'h0,         1, 32'h0000_0100, 1, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,         1, 32'h0000_0104, 1, 0, 0);
        tbl[3]  = mk(0, 1, 32'h0000_0200, 1, 32'h0000_0108, 1, 1, 0); // taken branch
        tbl[4]  = mk(0, 0, 32'h0,         1, 32'h0000_0200, 0, 0, 0); // bubble
        tbl[5]  = mk(0, 0, 32'h0,         1, 32'h0000_0200, 1, 0, 0);
        tbl[6]  = mk(1, 1, 32'h0000_0040, 1, 32'h0000_0204, 1, 1, 0); // redirect beats stall
        tbl[7]  = mk(0, 0, 32'h0,         1, 32'h0000_0040, 0, 0, 0);
        tbl[8]  = mk(0, 1, 32'h0000_0202, 1, 32'h0000_0040, 1, 0, 0); // misaligned
        tbl[9]  = mk(0, 0, 32'h0,         1, 32'h0000_0044, 1, 0, 1); // err pulse
        tbl[10] = mk(0, 0, 32'h0,         0, 32'h0000_0048, 1, 0, 0); // imem not ready
        tbl[11] = mk(1, 0, 32'h0,         1, 32'h0000_0048, 1, 0, 0); // stall
        tbl[12] = mk(0, 0, 32'h0,         0, 32'h0000_0048, 1, 0, 0);
        tbl[13] = mk(0, 1, 32'h0000_0080, 0, 32'h0000_0048, 1, 1, 0); // redirect beats !ready
        tbl[14] = mk(0, 1, 32'h0000_0090, 1, 32'h0000_0080, 0, 1, 0); // redirect in BUBBLE
        tbl[15] = mk(0, 0, 32'h0,         1, 32'h0000_0090, 0, 0, 0); // bubble restarted
        tbl[16] = mk(0, 1, 32'h0000_0091, 1, 32'h0000_0090, 1, 0, 0); // misaligned
        tbl[17] = mk(0, 0, 32'h0,         1, 32'h0000_0094, 1, 0, 1);
        tbl[18] = mk(0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0098, 1, 1, 0);
        tbl[19] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 0);
        tbl[20] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 0);
        tbl[21] = mk(0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, 0); // 32-bit wrap

        // One reset cycle; the first table row observes the post-reset state.
        drive(1, 0, 0, 32'h0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(0, tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
            chk_outs($sformatf("row%0d", i), tbl[i].exp_pc, tbl[i].exp_fv,
                     tbl[i].exp_fl, tbl[i].exp_err);
        end
`ifdef BRANCH_STATS_EN
        chk("table redirect_count", redirect_count, 32'd5);
        chk("table misalign_count", misalign_count, 32'd2);
`endif

        // Reset arriving mid-bubble together with a misaligned redirect.
        drive(0, 0, 1, 32'h0000_0600, 1);
        chk_outs("pre_rst_redirect", 32'h0000_0004, 1, 1, 0);
        drive(1, 0, 1, 32'h0000_0502, 1);
        chk_outs("rst_in_bubble", 32'h0000_0600, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 1);
        chk_outs("after_rst", 32'h0000_0100, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        chk("rst redirect_count", redirect_count, 32'd0);
        chk("rst misalign_count", misalign_count, 32'd0);
`endif

        // Three accepted redirects (two landing in BUBBLE) then one misaligned.
        drive(0, 0, 1, 32'h0000_0010, 1);
        chk_outs("chain1", 32'h0000_0100, 1, 1, 0);
        drive(0, 0, 1, 32'h0000_0020, 1);
        chk_outs("chain2", 32'h0000_0010, 0, 1, 0);
        drive(0, 0, 1, 32'h0000_0030, 1);
        chk_outs("chain3", 32'h0000_0020, 0, 1, 0);
        drive(0, 0, 1, 32'h0000_0033, 1);
        chk_outs("chain_mis", 32'h0000_0030, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0);
        chk_outs("chain_err", 32'h0000_0030, 1, 0, 1);
`ifdef BRANCH_STATS_EN
        chk("chain redirect_count", redirect_count, 32'd3);
        chk("chain misalign_count", misalign_count, 32'd1);
`endif
        drive(0, 0, 0, 32'h0, 1);
        chk_outs("err_one_cycle", 32'h0000_0030, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
